// File: rtl/sseg_mux_n.sv
// sseg_mux_n: N-digit multiplexed common-anode seven-segment driver.
// It scans the digits with a programmable slot length and decodes hex or BCD.
// It also handles leading-zero blanking, decimal points, per-digit blink and
// PWM brightness. Display data is double-buffered, and staging is committed
// only at a frame boundary.

// Per-digit decode: value -> active-low segments, with blanking and DP.
module sseg_lane (
  input  logic [3:0] nib,
  input  logic       hex_mode,
  input  logic       lz_blank,
  input  logic       blink_off,
  input  logic       dp_req,
  output logic [6:0] seg,
  output logic       dp
);
  // glyph lookup, then override with blank when suppressed
  always_comb begin
    seg = 7'b1111110;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = hex_mode ? 7'b0001000 : 7'b1111110;
      4'hB: seg = hex_mode ? 7'b1100000 : 7'b1111110;
      4'hC: seg = hex_mode ? 7'b0110001 : 7'b1111110;
      4'hD: seg = hex_mode ? 7'b1000010 : 7'b1111110;
      4'hE: seg = hex_mode ? 7'b0110000 : 7'b1111110;
      4'hF: seg = hex_mode ? 7'b0111000 : 7'b1111110;
      default: seg = 7'b1111110;
    endcase
    if (lz_blank || blink_off) seg = 7'b1111111;
    // a leading-zero blank keeps the DP; a blink blank hides it too
    dp = blink_off ? 1'b1 : ~dp_req;
  end
endmodule

module sseg_mux_n #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100_000,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 63
) (
  input  logic                    clk_100MHz,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic                    enable,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    busy
);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int FR_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // scan / timing state
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [FR_W-1:0]     frame_q, frame_d;
  logic                phase_q, phase_d;

  // staging and display buffers
  logic [NUM_DIGITS-1:0][3:0] stg_dig_q, stg_dig_d, dsp_dig_q, dsp_dig_d;
  logic [NUM_DIGITS-1:0]      stg_dp_q, stg_dp_d, dsp_dp_q, dsp_dp_d;
  logic [NUM_DIGITS-1:0]      stg_blk_q, stg_blk_d, dsp_blk_q, dsp_blk_d;
  logic                       busy_q, busy_d;

  // registered outputs
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // per-digit decoded view of the display buffer
  logic [NUM_DIGITS-1:0][6:0] seg_all;
  logic [NUM_DIGITS-1:0]      dp_all;
  logic [NUM_DIGITS-1:0]      upper_zero;
  logic [NUM_DIGITS-1:0]      lz_blank;

  logic slot_end, idx_end, frame_end;

  // upper_zero[i]: digits i..N-1 are all zero; digit 0 is never blanked
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    if (i == NUM_DIGITS - 1) begin : g_top
      assign upper_zero[i] = (dsp_dig_q[i] == 4'h0);
    end else begin : g_mid
      assign upper_zero[i] = (dsp_dig_q[i] == 4'h0) && upper_zero[i+1];
    end
    assign lz_blank[i] = blank_lz && (i != 0) && upper_zero[i];

    sseg_lane u_lane (
      .nib       (dsp_dig_q[i]),
      .hex_mode  (hex_mode),
      .lz_blank  (lz_blank[i]),
      .blink_off (phase_q && dsp_blk_q[i]),
      .dp_req    (dsp_dp_q[i]),
      .seg       (seg_all[i]),
      .dp        (dp_all[i])
    );
  end

  // next-state: counters, blink phase, double buffer, output drive
  always_comb begin
    slot_end  = (slot_q == SLOT_W'(REFRESH_DIV - 1));
    idx_end   = (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_end = slot_end && idx_end;

    slot_d  = slot_end ? '0 : slot_q + 1'b1;
    idx_d   = idx_q;
    if (slot_end) idx_d = idx_end ? '0 : idx_q + 1'b1;
    pwm_d   = pwm_q + 1'b1;

    frame_d = frame_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (frame_q == FR_W'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end

    // commit uses the old staging, so a coincident load stays pending
    stg_dig_d = stg_dig_q;
    stg_dp_d  = stg_dp_q;
    stg_blk_d = stg_blk_q;
    dsp_dig_d = dsp_dig_q;
    dsp_dp_d  = dsp_dp_q;
    dsp_blk_d = dsp_blk_q;
    busy_d    = busy_q;
    if (frame_end && busy_q) begin
      dsp_dig_d = stg_dig_q;
      dsp_dp_d  = stg_dp_q;
      dsp_blk_d = stg_blk_q;
      busy_d    = 1'b0;
    end
    if (load) begin
      stg_dig_d = digits;
      stg_dp_d  = dp_in;
      stg_blk_d = blink_mask;
      busy_d    = 1'b1;
    end

    seg_d = seg_all[idx_q];
    dp_d  = dp_all[idx_q];
    an_d  = '1;
    if (enable && (pwm_q <= brightness)) an_d[idx_q] = 1'b0;
  end

  // all state, async active-low reset
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      slot_q    <= '0;
      idx_q     <= '0;
      pwm_q     <= '0;
      frame_q   <= '0;
      phase_q   <= 1'b0;
      stg_dig_q <= '0;
      stg_dp_q  <= '0;
      stg_blk_q <= '0;
      dsp_dig_q <= '0;
      dsp_dp_q  <= '0;
      dsp_blk_q <= '0;
      busy_q    <= 1'b0;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
      an_q      <= '1;
    end else begin
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      pwm_q     <= pwm_d;
      frame_q   <= frame_d;
      phase_q   <= phase_d;
      stg_dig_q <= stg_dig_d;
      stg_dp_q  <= stg_dp_d;
      stg_blk_q <= stg_blk_d;
      dsp_dig_q <= dsp_dig_d;
      dsp_dp_q  <= dsp_dp_d;
      dsp_blk_q <= dsp_blk_d;
      busy_q    <= busy_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign SEG  = seg_q;
  assign DP   = dp_q;
  assign AN   = an_q;
  assign busy = busy_q;
endmodule
